data_mem_ctrl: RTL



---
 rtl/data_mem_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Data memory with request/done handshake, programmable wait states and
// little-endian byte/half/word/double accesses with sign/zero-extended loads.
module data_mem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Write_data,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    output logic [DATA_WIDTH-1:0] Read_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OB    = $clog2(BYTES);
    localparam int DEPTH = 2 ** (ADDR_WIDTH - OB);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    typedef struct packed {
        logic                  wr;
        logic                  uns;
        logic [1:0]            size;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                state, state_d;
    logic [3:0]            cnt, cnt_d;
    req_t                  rq, rq_d;
    logic                  done_d, err_d;
    logic [DATA_WIDTH-1:0] rdata_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-OB-1:0] widx;
    logic [OB-1:0]            off;
    assign widx = rq.addr[ADDR_WIDTH-1:OB];
    assign off  = rq.addr[OB-1:0];

    // Request screening happens on the live inputs while IDLE.
    logic req, misalign, bad;
    always_comb begin
        case (Size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = Address[0];
            2'd2:    misalign = |Address[1:0];
            default: misalign = |Address[2:0];
        endcase
    end
    assign req = MemRead | MemWrite;
    assign bad = (MemRead & MemWrite) | misalign | ((DATA_WIDTH == 32) && (Size == 2'd3));

    // Load path: shift addressed lane to bit 0, then mask and extend.
    logic [DATA_WIDTH-1:0] lane, mask, ld_ext;
    logic                  sgn;
    always_comb begin
        lane = mem[widx] >> {off, 3'b000};
        case (rq.size)
            2'd0:    begin mask = DATA_WIDTH'(8'hFF);         sgn = lane[7];            end
            2'd1:    begin mask = DATA_WIDTH'(16'hFFFF);      sgn = lane[15];           end
            2'd2:    begin mask = DATA_WIDTH'(32'hFFFF_FFFF); sgn = lane[31];           end
            default: begin mask = '1;                         sgn = lane[DATA_WIDTH-1]; end
        endcase
        ld_ext = (lane & mask) | ((!rq.uns && sgn) ? ~mask : '0);
    end

    // Store path: byte enables and data aligned to the addressed lane.
    logic [BYTES-1:0]      be_base, be;
    logic [DATA_WIDTH-1:0] wsh;
    always_comb begin
        case (rq.size)
            2'd0:    be_base = BYTES'(8'h01);
            2'd1:    be_base = BYTES'(8'h03);
            2'd2:    be_base = BYTES'(8'h0F);
            default: be_base = '1;
        endcase
        be  = be_base << off;
        wsh = rq.wdata << {off, 3'b000};
    end

    // Reset wins over the ACCESS edge so an interrupted store never lands.
    always_ff @(posedge clk) begin
        if (!reset && state == ACCESS && rq.wr) begin
            for (int b = 0; b < BYTES; b++)
                if (be[b]) mem[widx][b*8 +: 8] <= wsh[b*8 +: 8];
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rq_d    = rq;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = Read_data;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        rq_d    = '{wr: MemWrite, uns: Unsigned, size: Size,
                                    addr: Address, wdata: Write_data};
                        cnt_d   = CNT_INIT;
                        state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_d = ACCESS;
                else             cnt_d   = cnt - 4'd1;
            end
            ACCESS: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!rq.wr) rdata_d = ld_ext;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rq        <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            Read_data <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rq        <= rq_d;
            done      <= done_d;
            err       <= err_d;
            Read_data <= rdata_d;
        end
    end

    assign busy = (state != IDLE);

endmodule
